// File: rtl/fd_stage.sv
// fd_stage: F/D pipeline register plus branch/jump resolution in decode.
// Ports: clk, reset (sync, active-high), pause (hold F/D register),
//   F_PC/F_ins (from fetch), D_rs_val/D_rt_val (forwarded operands),
//   D_PC/D_ins/D_valid (F/D register), branch/DnPC (redirect to fetch).
// Optional: define BRANCH_LIKELY_EN to add beql/bnel with delay-slot
//   nullification on the not-taken path.
module fd_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_ins,
    input  logic [31:0] D_rs_val,
    input  logic [31:0] D_rt_val,
    output logic [31:0] D_PC,
    output logic [31:0] D_ins,
    output logic        D_valid,
    output logic        branch,
    output logic [31:0] DnPC
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
`ifdef BRANCH_LIKELY_EN
    localparam logic [5:0] OP_BEQL    = 6'b010100;
    localparam logic [5:0] OP_BNEL    = 6'b010101;
`endif
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_ins_q, d_ins_d;
    logic        d_valid_q, d_valid_d;

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        rs_eq_rt;
    logic        rs_zero;
    logic        rs_neg;
    logic        taken;
    logic [31:0] tgt;
    logic        likely;
    logic        nullify;

    // Decode and resolve from the F/D register contents.
    always_comb begin
        op       = d_ins_q[31:26];
        rt       = d_ins_q[20:16];
        funct    = d_ins_q[5:0];
        imm16    = d_ins_q[15:0];
        imm26    = d_ins_q[25:0];
        pc4      = d_pc_q + 32'd4;
        br_tgt   = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
        j_tgt    = {pc4[31:28], imm26, 2'b00};
        rs_eq_rt = (D_rs_val == D_rt_val);
        rs_zero  = (D_rs_val == 32'd0);
        rs_neg   = D_rs_val[31];
        taken    = 1'b0;
        tgt      = br_tgt;
        likely   = 1'b0;

        case (op)
            OP_BEQ:  taken = rs_eq_rt;
            OP_BNE:  taken = !rs_eq_rt;
            OP_BLEZ: taken = rs_neg || rs_zero;
            OP_BGTZ: taken = !rs_neg && !rs_zero;
            OP_REGIMM: begin
                if (rt == 5'b00001)
                    taken = !rs_neg;
                else if (rt == 5'b00000)
                    taken = rs_neg;
            end
            OP_J, OP_JAL: begin
                taken = 1'b1;
                tgt   = j_tgt;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    taken = 1'b1;
                    tgt   = D_rs_val;
                end
            end
`ifdef BRANCH_LIKELY_EN
            OP_BEQL: begin
                taken  = rs_eq_rt;
                likely = 1'b1;
            end
            OP_BNEL: begin
                taken  = !rs_eq_rt;
                likely = 1'b1;
            end
`endif
            default: taken = 1'b0;
        endcase

        branch  = d_valid_q && taken;
        DnPC    = branch ? tgt : (d_pc_q + 32'd8);
        // A not-taken likely branch squashes its delay slot on entry to D.
        nullify = d_valid_q && likely && !taken;
    end

    // Next-state for the F/D register; reset is applied in the flop.
    always_comb begin
        d_pc_d    = d_pc_q;
        d_ins_d   = d_ins_q;
        d_valid_d = d_valid_q;
        if (!pause) begin
            d_pc_d = F_PC;
            if (nullify) begin
                d_ins_d   = 32'd0;
                d_valid_d = 1'b0;
            end else begin
                d_ins_d   = F_ins;
                d_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_pc_q    <= RESET_PC;
            d_ins_q   <= 32'd0;
            d_valid_q <= 1'b0;
        end else begin
            d_pc_q    <= d_pc_d;
            d_ins_q   <= d_ins_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign D_PC    = d_pc_q;
    assign D_ins   = d_ins_q;
    assign D_valid = d_valid_q;

endmodule
